// File: rtl/i2c_pkg.sv
// Shared state encoding, bus-level constants and pointer helper for the
// fabric I2C register target.
package i2c_pkg;

   typedef enum logic [3:0] {
      IDLE,
      ADDR,
      ADDR_ACK,
      PTR,
      PTR_ACK,
      WDATA,
      WDATA_ACK,
      RDATA,
      RDATA_MACK,
      IGNORE
   } state_t;

   localparam logic ACK         = 1'b0;
   localparam logic NACK        = 1'b1;
   localparam int   SYNC_STAGES = 2;

   // Register pointer advance with wrap from the last register back to 0.
   function automatic logic [7:0] ptr_next(input logic [7:0] ptr, input logic [7:0] last);
      return (ptr == last) ? 8'd0 : ptr + 8'd1;
   endfunction

endpackage

// File: rtl/i2c_sync_edge.sv
// Pad-input synchronizer with a history flop; reports the synchronized level
// and single-cycle rise/fall pulses.
module i2c_sync_edge
   import i2c_pkg::*;
(
   input  logic clk,
   input  logic rst_n,
   input  logic din,
   output logic level,
   output logic rise,
   output logic fall
);

   logic [SYNC_STAGES:0] sh;

   // Reset to the idle-high bus level so no edge is reported out of reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) sh <= '1;
      else        sh <= {sh[SYNC_STAGES-1:0], din};
   end

   assign level = sh[SYNC_STAGES-1];
   assign rise  = level & ~sh[SYNC_STAGES];
   assign fall  = ~level & sh[SYNC_STAGES];

endmodule

// File: rtl/i2c_reg_target.sv
// I2C target exposing a byte-register write/read port to fabric logic.
// Pure responder: 7-bit addressing, no clock stretching, no general call.
module i2c_reg_target
   import i2c_pkg::*;
#(
   parameter logic [6:0] DEV_ADDR = 7'h42,
   parameter int         NUM_REGS = 8
)(
   input  logic       FAB_CLK,
   input  logic       MSS_RESET_N,
   input  logic       SCL_IN,
   input  logic       SDA_IN,
   output logic       SDA_OE,
   output logic [7:0] REG_ADDR,
   output logic [7:0] REG_WDATA,
   output logic       REG_WR_STB,
   input  logic [7:0] REG_RDATA,
   output logic       REG_RD_STB,
   output logic       BUSY
);

   localparam logic [7:0] LAST_REG  = 8'(NUM_REGS - 1);
   localparam logic [8:0] REG_LIMIT = 9'(NUM_REGS);

   logic scl, scl_rise, scl_fall;
   logic sda, sda_rise, sda_fall;

   i2c_sync_edge u_scl_sync (
      .clk   (FAB_CLK),
      .rst_n (MSS_RESET_N),
      .din   (SCL_IN),
      .level (scl),
      .rise  (scl_rise),
      .fall  (scl_fall)
   );

   i2c_sync_edge u_sda_sync (
      .clk   (FAB_CLK),
      .rst_n (MSS_RESET_N),
      .din   (SDA_IN),
      .level (sda),
      .rise  (sda_rise),
      .fall  (sda_fall)
   );

   state_t     state;
   logic [6:0] shreg;
   logic [2:0] bit_cnt;
   logic       rw;
   logic       ack_on;
   logic [7:0] byte_in;
   logic       start_det;
   logic       stop_det;

   // The 8th bit is never stored: the byte is evaluated on its own SCL rise.
   assign byte_in   = {shreg, sda};
   assign start_det = sda_fall & scl;
   assign stop_det  = sda_rise & scl;

   always_ff @(posedge FAB_CLK or negedge MSS_RESET_N) begin
      if (!MSS_RESET_N) begin
         state      <= IDLE;
         shreg      <= '0;
         bit_cnt    <= '0;
         rw         <= 1'b0;
         ack_on     <= 1'b0;
         SDA_OE     <= 1'b0;
         REG_ADDR   <= '0;
         REG_WDATA  <= '0;
         REG_WR_STB <= 1'b0;
         REG_RD_STB <= 1'b0;
         BUSY       <= 1'b0;
      end else begin
         REG_WR_STB <= 1'b0;
         REG_RD_STB <= 1'b0;
         if (start_det) begin
            state   <= ADDR;
            bit_cnt <= '0;
            ack_on  <= 1'b0;
            SDA_OE  <= 1'b0;
            BUSY    <= 1'b0;
         end else if (stop_det) begin
            state   <= IDLE;
            bit_cnt <= '0;
            ack_on  <= 1'b0;
            SDA_OE  <= 1'b0;
            BUSY    <= 1'b0;
         end else begin
            case (state)
               ADDR, PTR, WDATA: begin
                  if (scl_rise) begin
                     if (bit_cnt == 3'd7) begin
                        bit_cnt <= '0;
                        ack_on  <= 1'b0;
                        if (state == ADDR) begin
                           if (byte_in[7:1] == DEV_ADDR) begin
                              state <= ADDR_ACK;
                              rw    <= byte_in[0];
                              BUSY  <= 1'b1;
                           end else begin
                              state <= IGNORE;
                           end
                        end else if (state == PTR) begin
                           // Out-of-range pointer: stay silent (NACK), keep REG_ADDR.
                           if ({1'b0, byte_in} < REG_LIMIT) begin
                              REG_ADDR <= byte_in;
                              state    <= PTR_ACK;
                           end else begin
                              state <= IGNORE;
                           end
                        end else begin
                           REG_WDATA  <= byte_in;
                           REG_WR_STB <= 1'b1;
                           state      <= WDATA_ACK;
                        end
                     end else begin
                        shreg   <= byte_in[6:0];
                        bit_cnt <= bit_cnt + 3'd1;
                     end
                  end
               end

               ADDR_ACK, PTR_ACK, WDATA_ACK: begin
                  if (scl_fall) begin
                     if (!ack_on) begin
                        SDA_OE <= ~ACK;
                        ack_on <= 1'b1;
                     end else begin
                        ack_on <= 1'b0;
                        if (state == ADDR_ACK && rw) begin
                           shreg      <= REG_RDATA[6:0];
                           SDA_OE     <= ~REG_RDATA[7];
                           REG_RD_STB <= 1'b1;
                           state      <= RDATA;
                        end else begin
                           SDA_OE <= 1'b0;
                           state  <= (state == ADDR_ACK) ? PTR : WDATA;
                           if (state == WDATA_ACK) REG_ADDR <= ptr_next(REG_ADDR, LAST_REG);
                        end
                     end
                  end
               end

               RDATA: begin
                  if (scl_rise) begin
                     if (bit_cnt == 3'd7) begin
                        bit_cnt <= '0;
                        ack_on  <= 1'b0;
                        state   <= RDATA_MACK;
                     end else begin
                        bit_cnt <= bit_cnt + 3'd1;
                     end
                  end else if (scl_fall) begin
                     SDA_OE <= ~shreg[6];
                     shreg  <= {shreg[5:0], 1'b0};
                  end
               end

               RDATA_MACK: begin
                  // Pointer advances on the ACK rise so REG_RDATA settles before the next load.
                  if (scl_fall) begin
                     if (!ack_on) begin
                        SDA_OE <= 1'b0;
                        ack_on <= 1'b1;
                     end else begin
                        ack_on     <= 1'b0;
                        shreg      <= REG_RDATA[6:0];
                        SDA_OE     <= ~REG_RDATA[7];
                        REG_RD_STB <= 1'b1;
                        state      <= RDATA;
                     end
                  end else if (scl_rise && ack_on) begin
                     if (sda == NACK) begin
                        ack_on <= 1'b0;
                        state  <= IGNORE;
                     end else begin
                        REG_ADDR <= ptr_next(REG_ADDR, LAST_REG);
                     end
                  end
               end

               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_i2c_reg_target.sv
// Directed plus randomized I2C master transactions against a transaction-level
// model of the register target (pointer, expected strobes, expected read data).
module tb_i2c_reg_target;

   localparam int TQ    = 200;   // quarter SCL period in ns (10 FAB_CLK cycles)
   localparam int NREGS = 8;

   logic       clk   = 1'b0;
   logic       rst_n = 1'b0;
   logic       scl_m = 1'b1;
   logic       sda_m = 1'b1;
   logic       sda_oe, wr_stb, rd_stb, busy;
   logic [7:0] reg_addr, reg_wdata, reg_rdata;
   wire        sda_line = sda_m & ~sda_oe;

   int          n_vec = 0;
   int          n_err = 0;
   int          m_addr = 0;
   int          rd_cnt = 0;
   int          oe_cnt = 0;
   logic [15:0] obs_q[$];
   logic [7:0]  wd [4];

   always #10 clk = ~clk;

   // Fabric side: each register reads back as its address plus 0x10.
   assign reg_rdata = reg_addr + 8'h10;

   i2c_reg_target #(.DEV_ADDR(7'h42), .NUM_REGS(NREGS)) dut (
      .FAB_CLK     (clk),
      .MSS_RESET_N (rst_n),
      .SCL_IN      (scl_m),
      .SDA_IN      (sda_line),
      .SDA_OE      (sda_oe),
      .REG_ADDR    (reg_addr),
      .REG_WDATA   (reg_wdata),
      .REG_WR_STB  (wr_stb),
      .REG_RDATA   (reg_rdata),
      .REG_RD_STB  (rd_stb),
      .BUSY        (busy)
   );

   always @(posedge clk) begin
      if (wr_stb) obs_q.push_back({reg_addr, reg_wdata});
      if (rd_stb) rd_cnt <= rd_cnt + 1;
      if (sda_oe) oe_cnt <= oe_cnt + 1;
   end

   initial begin
      #2ms;
      $display("FAIL watchdog: observed timeout required finish");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic m_start();
      sda_m = 1'b1; #(TQ);
      scl_m = 1'b1; #(TQ);
      sda_m = 1'b0; #(TQ);
      scl_m = 1'b0; #(TQ);
   endtask

   task automatic m_stop();
      sda_m = 1'b0; #(TQ);
      scl_m = 1'b1; #(TQ);
      sda_m = 1'b1; #(TQ);
   endtask

   task automatic m_bit(input logic b, output logic s);
      sda_m = b;    #(TQ);
      scl_m = 1'b1; #(TQ);
      s = sda_line; #(TQ);
      scl_m = 1'b0; #(TQ);
   endtask

   task automatic m_write(input logic [7:0] b, output logic ack);
      logic s;
      for (int i = 7; i >= 0; i--) m_bit(b[i], s);
      m_bit(1'b1, ack);
   endtask

   task automatic m_read(input logic mack, output logic [7:0] d);
      logic s;
      for (int i = 7; i >= 0; i--) begin
         m_bit(1'b1, s);
         d[i] = s;
      end
      m_bit(mack, s);
      sda_m = 1'b1;
   endtask

   task automatic chk_writes(input string tag, input int base, input logic [15:0] e[$]);
      chk({tag, ".wr_count"}, 32'(obs_q.size() - base), 32'(e.size()));
      for (int i = 0; i < e.size(); i++)
         if (base + i < obs_q.size())
            chk($sformatf("%s.wr%0d", tag, i), 32'(obs_q[base + i]), 32'(e[i]));
   endtask

   // Write transaction: pointer byte then len data bytes taken from wd[].
   task automatic do_write(input int ptr, input int len, input string tag);
      logic        a;
      int          base;
      bit          ok;
      logic [15:0] e[$];
      base = obs_q.size();
      ok   = (ptr < NREGS);
      m_start();
      m_write(8'h84, a);
      chk({tag, ".addr_ack"}, 32'(a), 32'd0);
      chk({tag, ".busy"}, 32'(busy), 32'd1);
      m_write(8'(ptr), a);
      chk({tag, ".ptr_ack"}, 32'(a), ok ? 32'd0 : 32'd1);
      for (int i = 0; i < len; i++) begin
         m_write(wd[i], a);
         chk($sformatf("%s.d%0d_ack", tag, i), 32'(a), ok ? 32'd0 : 32'd1);
         if (ok) e.push_back({8'((ptr + i) % NREGS), wd[i]});
      end
      m_stop();
      if (ok) m_addr = (ptr + len) % NREGS;
      chk_writes(tag, base, e);
      chk({tag, ".reg_addr"}, 32'(reg_addr), 32'(m_addr));
      chk({tag, ".busy_end"}, 32'(busy), 32'd0);
   endtask

   // Combined read: set pointer, repeated START, read n bytes, NACK the last.
   task automatic do_read(input int ptr, input int n, input string tag);
      logic       a;
      logic [7:0] d;
      int         rd0, base;
      logic [15:0] e[$];
      base = obs_q.size();
      m_start();
      m_write(8'h84, a);
      chk({tag, ".addr_ack"}, 32'(a), 32'd0);
      m_write(8'(ptr), a);
      chk({tag, ".ptr_ack"}, 32'(a), 32'd0);
      rd0 = rd_cnt;
      m_start();
      m_write(8'h85, a);
      chk({tag, ".raddr_ack"}, 32'(a), 32'd0);
      for (int i = 0; i < n; i++) begin
         m_read((i == n - 1) ? 1'b1 : 1'b0, d);
         chk($sformatf("%s.rd%0d", tag, i), 32'(d), 32'(((ptr + i) % NREGS) + 16));
      end
      m_stop();
      m_addr = (ptr + n - 1) % NREGS;
      chk({tag, ".rd_stb_count"}, 32'(rd_cnt - rd0), 32'(n));
      chk({tag, ".reg_addr"}, 32'(reg_addr), 32'(m_addr));
      chk({tag, ".busy_end"}, 32'(busy), 32'd0);
      chk_writes(tag, base, e);
   endtask

   initial begin
      logic a, s;
      int   base, oe0;
      logic [15:0] none[$];

      repeat (3) @(negedge clk);
      chk("rst.sda_oe", 32'(sda_oe), 32'd0);
      chk("rst.reg_addr", 32'(reg_addr), 32'd0);
      chk("rst.reg_wdata", 32'(reg_wdata), 32'd0);
      chk("rst.wr_stb", 32'(wr_stb), 32'd0);
      chk("rst.rd_stb", 32'(rd_stb), 32'd0);
      chk("rst.busy", 32'(busy), 32'd0);
      rst_n = 1'b1;
      repeat (4) @(negedge clk);

      wd[0] = 8'hA5; wd[1] = 8'h5A;
      do_write(2, 2, "write");
      do_read(6, 2, "cread");

      // Foreign address: the target must never touch SDA.
      base = obs_q.size();
      oe0  = oe_cnt;
      m_start();
      m_write(8'h90, a); chk("wrong.addr_ack", 32'(a), 32'd1);
      m_write(8'h01, a); chk("wrong.b1_ack", 32'(a), 32'd1);
      m_write(8'h33, a); chk("wrong.b2_ack", 32'(a), 32'd1);
      m_stop();
      chk("wrong.oe_cycles", 32'(oe_cnt - oe0), 32'd0);
      chk_writes("wrong", base, none);
      chk("wrong.reg_addr", 32'(reg_addr), 32'(m_addr));

      wd[0] = 8'h11; wd[1] = 8'h22;
      do_write(8, 2, "badptr");
      wd[0] = 8'hC3; wd[1] = 8'h3C;
      do_write(7, 2, "wrap");

      // STOP after four data bits: partial byte is discarded.
      base = obs_q.size();
      m_start();
      m_write(8'h84, a); chk("abort.addr_ack", 32'(a), 32'd0);
      m_write(8'h03, a); chk("abort.ptr_ack", 32'(a), 32'd0);
      m_bit(1'b1, s); m_bit(1'b0, s); m_bit(1'b1, s); m_bit(1'b1, s);
      m_stop();
      m_addr = 3;
      chk_writes("abort", base, none);
      chk("abort.reg_addr", 32'(reg_addr), 32'(m_addr));

      for (int r = 0; r < 6; r++) begin
         if ($urandom_range(0, 1) == 1) begin
            for (int i = 0; i < 4; i++) wd[i] = 8'($urandom);
            do_write(int'($urandom_range(0, 9)), int'($urandom_range(1, 3)), $sformatf("rw%0d", r));
         end else begin
            do_read(int'($urandom_range(0, 7)), int'($urandom_range(1, 3)), $sformatf("rr%0d", r));
         end
      end

      // Reset in the middle of a read byte (register 5 reads 0x15 = 0001_0101).
      base = obs_q.size();
      m_start();
      m_write(8'h84, a);
      m_write(8'h05, a);
      m_start();
      m_write(8'h85, a); chk("rstrd.addr_ack", 32'(a), 32'd0);
      chk("rstrd.oe_bit7", 32'(sda_oe), 32'd1);
      m_bit(1'b1, s); m_bit(1'b1, s);
      chk("rstrd.oe_bit5", 32'(sda_oe), 32'd1);
      rst_n = 1'b0;
      #1;
      chk("rstrd.sda_oe", 32'(sda_oe), 32'd0);
      chk("rstrd.reg_addr", 32'(reg_addr), 32'd0);
      chk("rstrd.busy", 32'(busy), 32'd0);
      #19;
      rst_n  = 1'b1;
      m_addr = 0;
      repeat (4) @(negedge clk);
      m_stop();
      chk_writes("rstrd", base, none);
      wd[0] = 8'h77;
      do_write(1, 1, "post_rst");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
